// File: rtl/mc_controller_if.sv
// Handshake/bus bundle between the multi-cycle controller and its datapath/memory.
// The controller uses the slave view; the environment driving run/class/memReady uses master.
interface mc_controller_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [2:0]       instrClass;
    logic             memReady;
    logic             regsWriteEnable;
    logic             memReadEnable;
    logic             memWriteEnable;
    logic             pcWriteEnable;
    logic             irWriteEnable;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
    logic             illegal;

    modport master (
        output run, instrClass, memReady,
        input  regsWriteEnable, memReadEnable, memWriteEnable, pcWriteEnable,
               irWriteEnable, state, retired, illegal
    );

    modport slave (
        input  run, instrClass, memReady,
        output regsWriteEnable, memReadEnable, memWriteEnable, pcWriteEnable,
               irWriteEnable, state, retired, illegal
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle instruction controller: fetch/decode/execute FSM producing datapath enables,
// a retired-instruction counter and a sticky illegal-instruction halt.
module mc_controller #(
    parameter int MEM_WAIT  = 1,
    parameter int HANDSHAKE = 0,
    parameter int CNT_W     = 32
) (
    input  logic           clk,
    input  logic           rst,
    mc_controller_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_WB     = 4'd6,
        S_HALT   = 4'd7
    } state_t;

    localparam logic [3:0] MEM_WAIT_L = 4'(MEM_WAIT);

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    logic mem_done;
    logic instr_end;
    logic regs_we, mem_re, mem_we, pc_we, ir_we;

    // With HANDSHAKE=0 memReady is never looked at; with HANDSHAKE=1 the counter is never looked at.
    assign mem_done = (HANDSHAKE != 0) ? bus.memReady : (wait_q == MEM_WAIT_L);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        instr_end = 1'b0;
        regs_we   = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        pc_we     = 1'b0;
        ir_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_re = 1'b1;
                if (mem_done) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (bus.instrClass)
                    3'd0, 3'd4: state_d = S_WB;
                    3'd1:       state_d = S_MEMRD;
                    3'd2:       state_d = S_MEMWR;
                    3'd3:       instr_end = 1'b1;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMRD: begin
                mem_re = 1'b1;
                if (mem_done) state_d = S_WB;
            end
            S_MEMWR: begin
                mem_we = 1'b1;
                if (mem_done) instr_end = 1'b1;
            end
            S_WB: begin
                regs_we   = 1'b1;
                instr_end = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // run is only consulted here and in IDLE, so mid-instruction changes have no effect.
        if (instr_end) begin
            pc_we   = 1'b1;
            state_d = bus.run ? S_FETCH : S_IDLE;
        end
    end

    always_comb begin
        retired_d = retired_q + CNT_W'(instr_end);
        wait_d    = 4'd0;
        if ((state_d == state_q) &&
            ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= 4'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.regsWriteEnable = regs_we;
    assign bus.memReadEnable   = mem_re;
    assign bus.memWriteEnable  = mem_we;
    assign bus.pcWriteEnable   = pc_we;
    assign bus.irWriteEnable   = ir_we;
    assign bus.state           = state_q;
    assign bus.retired         = retired_q;
    assign bus.illegal         = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: three parameterisations, a cycle table,
// hand-written corner sequences and a randomized run against a phase-level model.
module tb_mc_controller;

    localparam int MW_A = 2;

    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DEC = 4'd2, EXEC = 4'd3;
    localparam logic [3:0] MEMRD = 4'd4, MEMWR = 4'd5, WB = 4'd6, HALT = 4'd7;

    localparam logic [4:0] NONE = 5'b00000, REG = 5'b10000, MRD = 5'b01000;
    localparam logic [4:0] MWR = 5'b00100, PC = 5'b00010, IR = 5'b00001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_controller_if #(.CNT_W(32)) ifa ();
    mc_controller_if #(.CNT_W(32)) ifb ();
    mc_controller_if #(.CNT_W(3))  ifc ();

    mc_controller #(.MEM_WAIT(MW_A), .HANDSHAKE(0), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mc_controller #(.MEM_WAIT(1),    .HANDSHAKE(1), .CNT_W(32)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    mc_controller #(.MEM_WAIT(0),    .HANDSHAKE(0), .CNT_W(3))  dut_c (.clk(clk), .rst(rst), .bus(ifc));

    logic [4:0] en_a, en_b, en_c;
    assign en_a = {ifa.regsWriteEnable, ifa.memReadEnable, ifa.memWriteEnable, ifa.pcWriteEnable, ifa.irWriteEnable};
    assign en_b = {ifb.regsWriteEnable, ifb.memReadEnable, ifb.memWriteEnable, ifb.pcWriteEnable, ifb.irWriteEnable};
    assign en_c = {ifc.regsWriteEnable, ifc.memReadEnable, ifc.memWriteEnable, ifc.pcWriteEnable, ifc.irWriteEnable};

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        run;
        logic [2:0]  cls;
        logic        mrdy;
        logic [3:0]  st;
        logic [4:0]  en;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] rc();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic void add(input logic r, input logic [2:0] c, input logic m,
                                input logic [3:0] s, input logic [4:0] e, input logic [31:0] rt);
        vec_t v;
        v.run = r; v.cls = c; v.mrdy = m; v.st = s; v.en = e; v.ret = rt;
        tbl.push_back(v);
    endfunction

    // Each step starts 1 time unit after a rising edge: drive, sample, then advance one cycle.
    task automatic step_a(input string name, input logic r, input logic [2:0] c, input logic m,
                          input logic [3:0] es, input logic [4:0] ee, input logic [31:0] eret);
        ifa.run = r; ifa.instrClass = c; ifa.memReady = m;
        #1;
        check(name, {ifa.state, en_a, ifa.retired, ifa.illegal}, {es, ee, eret, 1'b0});
        check("rd_wr_exclusive_a", {63'd0, en_a[3] & en_a[2]}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic step_b(input string name, input logic r, input logic [2:0] c, input logic m,
                          input logic [3:0] es, input logic [4:0] ee, input logic [31:0] eret);
        ifb.run = r; ifb.instrClass = c; ifb.memReady = m;
        #1;
        check(name, {ifb.state, en_b, ifb.retired, ifb.illegal}, {es, ee, eret, 1'b0});
        @(posedge clk); #1;
    endtask

    task automatic step_c(input string name, input logic r, input logic [2:0] c,
                          input logic [3:0] es, input logic [4:0] ee, input logic [2:0] eret, input logic eill);
        ifc.run = r; ifc.instrClass = c; ifc.memReady = 1'b0;
        #1;
        check(name, {ifc.state, en_c, ifc.retired, ifc.illegal}, {es, ee, eret, eill});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        ifa.run = 1'b0; ifb.run = 1'b0; ifc.run = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r;
        logic [2:0] cls;
        logic [31:0] ret_m;
        logic in_idle;

        ifa.run = 1'b0; ifa.instrClass = 3'd0; ifa.memReady = 1'b0;
        ifb.run = 1'b0; ifb.instrClass = 3'd0; ifb.memReady = 1'b0;
        ifc.run = 1'b0; ifc.instrClass = 3'd0; ifc.memReady = 1'b0;
        rst = 1'b1;
        #1;
        check("reset_a", {ifa.state, en_a, ifa.retired, ifa.illegal}, 64'd0);
        check("reset_b", {ifb.state, en_b, ifb.retired, ifb.illegal}, 64'd0);
        check("reset_c", {ifc.state, en_c, ifc.retired, ifc.illegal}, 64'd0);
        do_reset();

        // ALU, LOAD, BRANCH, STORE back-to-back, JUMP with run dropped mid-instruction.
        add(1, 5, 1, IDLE, NONE, 0);
        add(1, 5, 1, FETCH, MRD, 0); add(1, 5, 1, FETCH, MRD, 0); add(1, 5, 1, FETCH, MRD | IR, 0);
        add(1, 7, 1, DEC, NONE, 0);
        add(1, 0, 1, EXEC, NONE, 0);
        add(0, 7, 1, WB, REG | PC, 0);
        add(1, 5, 0, IDLE, NONE, 1);
        add(1, 5, 0, FETCH, MRD, 1); add(1, 5, 0, FETCH, MRD, 1); add(1, 5, 0, FETCH, MRD | IR, 1);
        add(1, 6, 0, DEC, NONE, 1);
        add(1, 1, 0, EXEC, NONE, 1);
        add(1, 7, 1, MEMRD, MRD, 1); add(1, 7, 1, MEMRD, MRD, 1); add(1, 7, 1, MEMRD, MRD, 1);
        add(0, 7, 0, WB, REG | PC, 1);
        add(1, 5, 0, IDLE, NONE, 2);
        add(1, 5, 0, FETCH, MRD, 2); add(1, 5, 0, FETCH, MRD, 2); add(1, 5, 0, FETCH, MRD | IR, 2);
        add(1, 7, 0, DEC, NONE, 2);
        add(0, 3, 0, EXEC, PC, 2);
        add(1, 5, 0, IDLE, NONE, 3);
        add(1, 5, 0, FETCH, MRD, 3); add(1, 5, 0, FETCH, MRD, 3); add(1, 5, 0, FETCH, MRD | IR, 3);
        add(1, 7, 0, DEC, NONE, 3);
        add(1, 2, 0, EXEC, NONE, 3);
        add(1, 6, 1, MEMWR, MWR, 3); add(1, 6, 1, MEMWR, MWR, 3); add(1, 6, 0, MEMWR, MWR | PC, 3);
        add(0, 5, 0, FETCH, MRD, 4); add(0, 5, 0, FETCH, MRD, 4); add(0, 5, 0, FETCH, MRD | IR, 4);
        add(0, 7, 0, DEC, NONE, 4);
        add(0, 4, 0, EXEC, NONE, 4);
        add(0, 7, 0, WB, REG | PC, 4);
        add(0, 5, 0, IDLE, NONE, 5); add(0, 5, 0, IDLE, NONE, 5);

        for (int i = 0; i < tbl.size(); i++) begin
            step_a($sformatf("table_row_%0d", i), tbl[i].run, tbl[i].cls, tbl[i].mrdy,
                   tbl[i].st, tbl[i].en, tbl[i].ret);
        end

        // Asynchronous reset in the middle of a load access.
        step_a("mr_idle", 1, 0, 0, IDLE, NONE, 5);
        for (int k = 0; k <= MW_A; k++) step_a("mr_fetch", 1, 1, 0, FETCH, (k == MW_A) ? (MRD | IR) : MRD, 5);
        step_a("mr_dec", 1, 1, 0, DEC, NONE, 5);
        step_a("mr_exec", 1, 1, 0, EXEC, NONE, 5);
        step_a("mr_memrd0", 1, 1, 0, MEMRD, MRD, 5);
        #1;
        check("pre_rst_memrd", {ifa.state, en_a}, {MEMRD, MRD});
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {ifa.state, en_a, ifa.retired, ifa.illegal}, 64'd0);
        @(posedge clk); #1;
        check("rst_held", {ifa.state, en_a}, {IDLE, NONE});
        #2;
        rst = 1'b0;
        #1;
        check("rst_release_same_cycle", {ifa.state, en_a}, {IDLE, NONE});
        @(posedge clk); #1;
        check("first_edge_after_release", {ifa.state, en_a}, {FETCH, MRD});

        // Handshake memory: fetch finishes on memReady, store held 4 extra cycles.
        do_reset();
        step_b("hs_idle", 1, rc(), 1, IDLE, NONE, 0);
        step_b("hs_fetch0", 1, rc(), 0, FETCH, MRD, 0);
        step_b("hs_fetch1", 1, rc(), 0, FETCH, MRD, 0);
        step_b("hs_fetch_done", 1, rc(), 1, FETCH, MRD | IR, 0);
        step_b("hs_dec", 1, rc(), 1, DEC, NONE, 0);
        step_b("hs_exec", 1, 2, 1, EXEC, NONE, 0);
        for (int k = 0; k < 4; k++) step_b("hs_memwr_wait", 1, rc(), 0, MEMWR, MWR, 0);
        step_b("hs_memwr_done", 0, rc(), 1, MEMWR, MWR | PC, 0);
        step_b("hs_after", 0, rc(), 1, IDLE, NONE, 1);

        // Narrow counter wrap through nine branches, then an illegal class into HALT.
        do_reset();
        step_c("w_idle", 1, rc(), IDLE, NONE, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step_c("w_fetch", 1, rc(), FETCH, MRD | IR, 3'(i), 0);
            step_c("w_dec", 1, rc(), DEC, NONE, 3'(i), 0);
            step_c($sformatf("w_branch_%0d", i), 1, 3, EXEC, PC, 3'(i), 0);
        end
        step_c("w_retired_after_wrap", 1, rc(), FETCH, MRD | IR, 3'd1, 0);
        step_c("ill_dec", 1, rc(), DEC, NONE, 1, 0);
        step_c("ill_exec", 1, 6, EXEC, NONE, 1, 0);
        for (int k = 0; k < 20; k++) step_c("halt_hold", 1, rc(), HALT, NONE, 1, 1);
        do_reset();
        step_c("halt_cleared_by_rst", 0, rc(), IDLE, NONE, 0, 0);

        // Randomized instructions on the fixed-wait instance against a phase model.
        do_reset();
        ret_m = 0;
        in_idle = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (in_idle) begin
                do begin
                    r = 1'($urandom_range(0, 1));
                    step_a("rnd_idle", r, rc(), 1'($urandom), IDLE, NONE, ret_m);
                end while (!r);
            end
            cls = 3'($urandom_range(0, 4));
            for (int k = 0; k <= MW_A; k++)
                step_a("rnd_fetch", 1'($urandom), rc(), 1'($urandom), FETCH, (k == MW_A) ? (MRD | IR) : MRD, ret_m);
            step_a("rnd_dec", 1'($urandom), rc(), 1'($urandom), DEC, NONE, ret_m);
            r = 1'($urandom_range(0, 1));
            if (cls == 3'd3) begin
                step_a("rnd_branch", r, cls, 1'($urandom), EXEC, PC, ret_m);
            end else begin
                step_a("rnd_exec", 1'($urandom), cls, 1'($urandom), EXEC, NONE, ret_m);
                if (cls == 3'd1) begin
                    for (int k = 0; k <= MW_A; k++)
                        step_a("rnd_memrd", 1'($urandom), rc(), 1'($urandom), MEMRD, MRD, ret_m);
                end
                if (cls == 3'd2) begin
                    for (int k = 0; k < MW_A; k++)
                        step_a("rnd_memwr", 1'($urandom), rc(), 1'($urandom), MEMWR, MWR, ret_m);
                    step_a("rnd_memwr_end", r, rc(), 1'($urandom), MEMWR, MWR | PC, ret_m);
                end else begin
                    step_a("rnd_wb", r, rc(), 1'($urandom), WB, REG | PC, ret_m);
                end
            end
            ret_m = ret_m + 1;
            in_idle = !r;
        end
        step_a("rnd_final", 0, rc(), 0, in_idle ? IDLE : FETCH, in_idle ? NONE : MRD, ret_m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, extra wait cycles per memory access when HANDSHAKE=0 (legal range 0..15).
REQ-002 SHALL have parameter HANDSHAKE, default 0, 1 = memory completion by memReady, 0 = fixed MEM_WAIT count.
REQ-003 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port run  input  1  allow fetch of the next instruction.
REQ-007 SHALL have port instrClass  input  3  decoded class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5-7 illegal.
REQ-008 SHALL have port memReady  input  1  memory access complete (used only when HANDSHAKE=1).
REQ-009 SHALL have outputs regsWriteEnable, memReadEnable, memWriteEnable, pcWriteEnable, irWriteEnable  output  1 each  datapath enables.
REQ-010 SHALL have port state  output  4  current FSM state code.
REQ-011 SHALL have port retired  output  CNT_W  count of completed instructions.
REQ-012 SHALL have port illegal  output  1  sticky flag, high in HALT.

Function
REQ-013 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEMRD=4, MEMWR=5, WB=6, HALT=7, registered in one state register.
REQ-014 SHALL define memDone as follows: HANDSHAKE=1 -> memReady high; HANDSHAKE=0 -> wait counter == MEM_WAIT.
REQ-015 SHALL clear the wait counter on entry to FETCH, MEMRD or MEMWR and increment it each cycle the FSM stays in that state; a MEM_WAIT=0 access therefore lasts 1 cycle.
REQ-016 SHALL transition from IDLE to FETCH when run=1, else stay in IDLE.
REQ-017 SHALL, in FETCH, hold memReadEnable=1, assert irWriteEnable only in the memDone cycle, and go to DECODE on memDone.
REQ-018 SHALL always transition from DECODE to EXEC after 1 cycle.
REQ-019 SHALL, in EXEC, branch on instrClass (sampled in EXEC): ALU/JUMP -> WB; LOAD -> MEMRD; STORE -> MEMWR; BRANCH -> end of instruction; 5-7 -> HALT.
REQ-020 SHALL, in MEMRD, hold memReadEnable=1 and go to WB on memDone.
REQ-021 SHALL, in MEMWR, hold memWriteEnable=1; memDone ends the instruction.
REQ-022 SHALL, in WB, assert regsWriteEnable=1 for exactly 1 cycle and end the instruction.
REQ-023 SHALL, at the end of an instruction (WB, MEMWR+memDone, EXEC+BRANCH), assert pcWriteEnable for that single cycle, increment retired, and go to FETCH if run=1, else to IDLE.
REQ-024 SHALL wrap retired from all-ones to 0 without flagging.
REQ-025 SHALL keep HALT absorbing until rst, with all enables 0 and illegal=1; the illegal instruction does not increment retired.
REQ-026 SHALL decode all enables combinationally from state, memDone and instrClass, with no enable asserted in IDLE, DECODE or HALT.
REQ-027 SHALL never assert memReadEnable and memWriteEnable in the same cycle.
REQ-028 SHALL ignore a change of run mid-instruction; run is sampled only in IDLE and at instruction end.
REQ-029 SHALL ignore memReady when HANDSHAKE=0, and SHALL leave the wait counter's value irrelevant when HANDSHAKE=1.

Reset
REQ-030 SHALL, on rst high (asynchronous, any state, mid-access included), immediately force state=IDLE, wait counter=0, retired=0, illegal=0, and all enables 0.
REQ-031 SHALL leave IDLE no earlier than the first rising clk edge after rst deasserts.

Verification
REQ-032 SHALL cover: MEM_WAIT=2, HANDSHAKE=0, run=1, class 0 -> FETCH 3 cycles, DECODE 1, EXEC 1, WB 1; regsWriteEnable and pcWriteEnable both high in cycle 6; retired=1.
REQ-033 SHALL cover: MEM_WAIT=2, class 1 -> 9-cycle instruction, memReadEnable high in 6 cycles, irWriteEnable high in cycle 3 only.
REQ-034 SHALL cover: HANDSHAKE=1, class 2, memReady low 4 cycles in MEMWR and then high -> memWriteEnable high for 5 cycles, pcWriteEnable in the 5th only.
REQ-035 SHALL cover: class 6 in EXEC -> HALT, illegal=1, retired unchanged, and HALT held for 20 cycles despite run=1.
REQ-036 SHALL cover: CNT_W=3, 9 BRANCH instructions -> retired sequence ending at 7 then 0 then 1.
REQ-037 SHALL cover: rst pulsed mid-MEMRD -> same-cycle state=0, all enables 0; run=0 at an instruction end -> IDLE, no further fetch.
